// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared types, size codes and byte-enable helper for mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   // ResultSrc encoding that selects memory data for writeback
   localparam logic [1:0] RES_MEM = 2'b01;

   function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] a);
      case (size)
         SZ_B:    be_from_size = 4'b0001 << a;
         SZ_H:    be_from_size = 4'b0011 << a;
         default: be_from_size = 4'b1111;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ex_to_mem_if.sv
// ============================================================================
// ex_to_mem_if : EX/MEM pipeline bundle between Execute and Memory
// Rev 1.0
// ============================================================================
`default_nettype none

interface ex_to_mem_if;

   logic [31:0] alu_result;
   logic [4:0]  rd;
   logic [31:0] rd2;
   logic [2:0]  funct3;
   logic        MemWrite;
   logic        RegWrite;
   logic [1:0]  ResultSrc;

   modport Execute (
      output alu_result, rd, rd2, funct3, MemWrite, RegWrite, ResultSrc
   );

   modport Memory (
      input alu_result, rd, rd2, funct3, MemWrite, RegWrite, ResultSrc
   );

endinterface

`default_nettype wire

// File: rtl/mem_stage_load_extend.sv
// ============================================================================
// load_extend : selects the addressed lane of a load word and sign/zero-extends it
// Rev 1.0
// ============================================================================
`default_nettype none

module load_extend
   import mem_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [15:0] w_lane;
   logic        w_sign;

   always_comb begin
      w_lane = 16'(rdata >> {off, 3'b000});
      w_sign = 1'b0;
      case (funct3[1:0])
         SZ_B: begin
            w_sign = w_lane[7] & ~funct3[2];
            result = {{24{w_sign}}, w_lane[7:0]};
         end
         SZ_H: begin
            w_sign = w_lane[15] & ~funct3[2];
            result = {{16{w_sign}}, w_lane[15:0]};
         end
         default: result = rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : EX->MEM consumer; req/ack data-memory access and MEM/WB register
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                reset,
   ex_to_mem_if.Memory         ex,
   input  logic                ex_valid,
   output logic                mem_stall,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [31:0]         dmem_addr,
   output logic [31:0]         dmem_wdata,
   output logic [3:0]          dmem_be,
   input  logic [31:0]         dmem_rdata,
   input  logic                dmem_ack,
   output logic                wb_valid,
   output logic                wb_reg_write,
   output logic [4:0]          wb_rd,
   output logic [31:0]         wb_result,
   output logic                mem_fault
);

   localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   mem_state_e        r_state;
   mem_state_e        w_next;

   logic              r_req;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_be;
   logic [31:0]       r_alu;
   logic [4:0]        r_rd;
   logic [2:0]        r_funct3;
   logic              r_reg_write;
   logic [CNT_W-1:0]  r_cnt;

   logic              r_wb_valid;
   logic              r_wb_reg_write;
   logic [4:0]        r_wb_rd;
   logic [31:0]       r_wb_result;
   logic              r_fault;

   logic              w_store;
   logic              w_load;
   logic [1:0]        w_size;
   logic [1:0]        w_off;
   logic              w_misaligned;
   logic              w_memop;
   logic              w_accept;
   logic              w_timeout;
   logic [31:0]       w_wdata;
   logic [31:0]       w_ext;

   assign w_store = |ex.MemWrite;
   assign w_load  = (ex.ResultSrc == RES_MEM);
   assign w_size  = ex.funct3[1:0];
   assign w_off   = ex.alu_result[1:0];

   // Any size code other than byte/half is treated as a word for alignment
   assign w_misaligned = ((w_size == SZ_H) && w_off[0]) ||
                         ((w_size != SZ_B) && (w_size != SZ_H) && (w_off != 2'b00));

   assign w_memop   = ex_valid && (w_load || w_store);
   assign w_accept  = (r_state == IDLE) && w_memop && !w_misaligned;
   assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

   always_comb begin
      case (w_size)
         SZ_B:    w_wdata = {4{ex.rd2[7:0]}};
         SZ_H:    w_wdata = {2{ex.rd2[15:0]}};
         default: w_wdata = ex.rd2;
      endcase
   end

   load_extend u_load_extend (
      .rdata  (dmem_rdata),
      .off    (r_alu[1:0]),
      .funct3 (r_funct3),
      .result (w_ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_stall = 1'b0;
      case (r_state)
         IDLE: begin
            mem_stall = w_memop;
            if (w_accept) begin
               w_next = WAIT;
            end
         end
         WAIT: begin
            mem_stall = 1'b1;
            if (dmem_ack || w_timeout) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_req          <= 1'b0;
         r_we           <= 1'b0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_be           <= '0;
         r_alu          <= '0;
         r_rd           <= '0;
         r_funct3       <= '0;
         r_reg_write    <= 1'b0;
         r_cnt          <= '0;
         r_wb_valid     <= 1'b0;
         r_wb_reg_write <= 1'b0;
         r_wb_rd        <= '0;
         r_wb_result    <= '0;
         r_fault        <= 1'b0;
      end else begin
         r_wb_valid     <= 1'b0;
         r_wb_reg_write <= 1'b0;
         r_fault        <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req       <= 1'b1;
                  r_we        <= w_store;
                  r_addr      <= {ex.alu_result[31:2], 2'b00};
                  r_wdata     <= w_wdata;
                  r_be        <= be_from_size(w_size, w_off);
                  r_alu       <= ex.alu_result;
                  r_rd        <= ex.rd;
                  r_funct3    <= ex.funct3;
                  r_reg_write <= ex.RegWrite;
                  r_cnt       <= '0;
               end else if (w_memop) begin
                  // Misaligned access retires immediately without a bus cycle
                  r_fault     <= 1'b1;
                  r_wb_valid  <= 1'b1;
                  r_wb_rd     <= ex.rd;
                  r_wb_result <= ex.alu_result;
               end else begin
                  r_wb_valid     <= ex_valid;
                  r_wb_reg_write <= ex_valid && ex.RegWrite;
                  r_wb_rd        <= ex.rd;
                  r_wb_result    <= ex.alu_result;
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  r_req          <= 1'b0;
                  r_wb_valid     <= 1'b1;
                  r_wb_reg_write <= !r_we && r_reg_write;
                  r_wb_rd        <= r_rd;
                  r_wb_result    <= r_we ? r_alu : w_ext;
               end else if (w_timeout) begin
                  r_req       <= 1'b0;
                  r_fault     <= 1'b1;
                  r_wb_valid  <= 1'b1;
                  r_wb_rd     <= r_rd;
                  r_wb_result <= r_alu;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign dmem_req     = r_req;
   assign dmem_we      = r_we;
   assign dmem_addr    = r_addr;
   assign dmem_wdata   = r_wdata;
   assign dmem_be      = r_be;
   assign wb_valid     = r_wb_valid;
   assign wb_reg_write = r_wb_reg_write;
   assign wb_rd        = r_wb_rd;
   assign wb_result    = r_wb_result;
   assign mem_fault    = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed self-checking bench for mem_stage (TIMEOUT_CYCLES=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        mem_stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_result;
   logic        mem_fault;

   int n_cmp = 0;
   int n_bad = 0;

   ex_to_mem_if ex_if ();

   mem_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .ex           (ex_if),
      .ex_valid     (ex_valid),
      .mem_stall    (mem_stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_wdata   (dmem_wdata),
      .dmem_be      (dmem_be),
      .dmem_rdata   (dmem_rdata),
      .dmem_ack     (dmem_ack),
      .wb_valid     (wb_valid),
      .wb_reg_write (wb_reg_write),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .mem_fault    (mem_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [2:0] f3,
                        input logic mw, input logic [1:0] rs, input logic rw,
                        input logic [4:0] rd, input logic [31:0] rd2);
      ex_valid           = v;
      ex_if.alu_result   = alu;
      ex_if.funct3       = f3;
      ex_if.MemWrite     = mw;
      ex_if.ResultSrc    = rs;
      ex_if.RegWrite     = rw;
      ex_if.rd           = rd;
      ex_if.rd2          = rd2;
   endtask

   // One aligned access: accept, `waits` WAIT cycles without ack, then an ack cycle
   task automatic mem_op(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic st, input logic [31:0] rd2, input logic [4:0] rd,
                         input logic [31:0] rdata, input int waits,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wdata, input logic [31:0] e_res,
                         input logic e_rw);
      drive(1'b1, addr, f3, st, st ? 2'b00 : 2'b01, 1'b1, rd, rd2);
      #1;
      check({tag, ".stall_accept"}, 32'(mem_stall), 32'd1);
      check({tag, ".req_accept"},   32'(dmem_req),  32'd0);
      tick();
      ex_valid = 1'b0;
      #1;
      check({tag, ".req"},  32'(dmem_req), 32'd1);
      check({tag, ".we"},   32'(dmem_we),  32'(st));
      check({tag, ".addr"}, dmem_addr,     e_addr);
      check({tag, ".be"},   32'(dmem_be),  32'(e_be));
      if (st) check({tag, ".wdata"}, dmem_wdata, e_wdata);
      for (int i = 0; i < waits; i++) begin
         tick();
         #1;
         check({tag, ".req_held"},   32'(dmem_req),  32'd1);
         check({tag, ".stall_wait"}, 32'(mem_stall), 32'd1);
         check({tag, ".addr_held"},  dmem_addr,      e_addr);
         check({tag, ".wbv_wait"},   32'(wb_valid),  32'd0);
      end
      dmem_ack   = 1'b1;
      dmem_rdata = rdata;
      #1;
      check({tag, ".stall_ack"}, 32'(mem_stall), 32'd1);
      tick();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      #1;
      check({tag, ".wb_valid"},  32'(wb_valid),     32'd1);
      check({tag, ".wb_rd"},     32'(wb_rd),        32'(rd));
      check({tag, ".wb_result"}, wb_result,         e_res);
      check({tag, ".wb_rw"},     32'(wb_reg_write), 32'(e_rw));
      check({tag, ".fault"},     32'(mem_fault),    32'd0);
      check({tag, ".req_drop"},  32'(dmem_req),     32'd0);
      check({tag, ".stall_end"}, 32'(mem_stall),    32'd0);
   endtask

   task automatic misaligned(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                             input logic st);
      drive(1'b1, addr, f3, st, st ? 2'b00 : 2'b01, 1'b1, 5'd9, 32'h1111_2222);
      #1;
      check({tag, ".stall"}, 32'(mem_stall), 32'd1);
      tick();
      ex_valid = 1'b0;
      #1;
      check({tag, ".no_req"},   32'(dmem_req),     32'd0);
      check({tag, ".fault"},    32'(mem_fault),    32'd1);
      check({tag, ".wb_valid"}, 32'(wb_valid),     32'd1);
      check({tag, ".wb_rw"},    32'(wb_reg_write), 32'd0);
      check({tag, ".stall1"},   32'(mem_stall),    32'd0);
      tick();
      check({tag, ".fault_end"}, 32'(mem_fault), 32'd0);
      check({tag, ".wbv_end"},   32'(wb_valid),  32'd0);
      check({tag, ".no_req2"},   32'(dmem_req),  32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      drive(1'b0, 32'h0, 3'b000, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0);
      #3;
      check("reset.req",      32'(dmem_req),     32'd0);
      check("reset.wb_valid", 32'(wb_valid),     32'd0);
      check("reset.wb_rw",    32'(wb_reg_write), 32'd0);
      check("reset.fault",    32'(mem_fault),    32'd0);
      check("reset.addr",     dmem_addr,         32'h0);
      check("reset.be",       32'(dmem_be),      32'd0);
      tick();
      tick();
      reset = 1'b0;

      // Pass-through ADD
      tick();
      drive(1'b1, 32'h0000_1234, 3'b000, 1'b0, 2'b00, 1'b1, 5'd5, 32'h0);
      #1;
      check("pass.stall", 32'(mem_stall), 32'd0);
      tick();
      ex_valid = 1'b0;
      #1;
      check("pass.wb_valid",  32'(wb_valid),     32'd1);
      check("pass.wb_rd",     32'(wb_rd),        32'd5);
      check("pass.wb_result", wb_result,         32'h0000_1234);
      check("pass.wb_rw",     32'(wb_reg_write), 32'd1);
      check("pass.no_req",    32'(dmem_req),     32'd0);
      tick();
      check("bubble.wb_valid", 32'(wb_valid), 32'd0);

      tick();
      mem_op("lb",  32'h0000_1003, 3'b000, 1'b0, 32'h0, 5'd7, 32'h80FF_FF00, 2,
             32'h0000_1000, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1);
      mem_op("lbu", 32'h0000_1003, 3'b100, 1'b0, 32'h0, 5'd8, 32'h80FF_FF00, 2,
             32'h0000_1000, 4'b1000, 32'h0, 32'h0000_0080, 1'b1);
      mem_op("sh",  32'h0000_2002, 3'b001, 1'b1, 32'h0000_ABCD, 5'd3, 32'h0, 0,
             32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_2002, 1'b0);
      mem_op("lh",  32'h0000_4002, 3'b001, 1'b0, 32'h0, 5'd10, 32'h8001_1234, 1,
             32'h0000_4000, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1);
      mem_op("lhu", 32'h0000_4002, 3'b101, 1'b0, 32'h0, 5'd11, 32'h8001_1234, 0,
             32'h0000_4000, 4'b1100, 32'h0, 32'h0000_8001, 1'b1);
      mem_op("sb",  32'h0000_6001, 3'b000, 1'b1, 32'h1234_55AA, 5'd12, 32'h0, 1,
             32'h0000_6000, 4'b0010, 32'hAAAA_AAAA, 32'h0000_6001, 1'b0);
      mem_op("sw",  32'h0000_7008, 3'b010, 1'b1, 32'hCAFE_F00D, 5'd13, 32'h0, 0,
             32'h0000_7008, 4'b1111, 32'hCAFE_F00D, 32'h0000_7008, 1'b0);
      // Ack lands in the same cycle the timeout would fire
      mem_op("lw_ack4", 32'h0000_5004, 3'b010, 1'b0, 32'h0, 5'd14, 32'hDEAD_BEEF, 3,
             32'h0000_5004, 4'b1111, 32'h0, 32'hDEAD_BEEF, 1'b1);
      mem_op("lb0", 32'h0000_8000, 3'b000, 1'b0, 32'h0, 5'd15, 32'h1234_567F, 0,
             32'h0000_8000, 4'b0001, 32'h0, 32'h0000_007F, 1'b1);

      tick();
      misaligned("mis_lw", 32'h0000_3001, 3'b010, 1'b0);
      misaligned("mis_sh", 32'h0000_2001, 3'b001, 1'b1);

      // Timeout with no ack
      drive(1'b1, 32'h0000_7000, 3'b010, 1'b0, 2'b01, 1'b1, 5'd20, 32'h0);
      tick();
      ex_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("tmo.req_held", 32'(dmem_req),  32'd1);
         check("tmo.fault0",   32'(mem_fault), 32'd0);
         tick();
      end
      #1;
      check("tmo.req_drop", 32'(dmem_req),     32'd0);
      check("tmo.fault",    32'(mem_fault),    32'd1);
      check("tmo.wb_valid", 32'(wb_valid),     32'd1);
      check("tmo.wb_rw",    32'(wb_reg_write), 32'd0);
      check("tmo.stall",    32'(mem_stall),    32'd0);
      tick();
      check("tmo.fault_end", 32'(mem_fault), 32'd0);

      // Reset two cycles into WAIT
      drive(1'b1, 32'h0000_9000, 3'b010, 1'b0, 2'b01, 1'b1, 5'd21, 32'h0);
      tick();
      ex_valid = 1'b0;
      tick();
      #1;
      check("rst_wait.req_before", 32'(dmem_req), 32'd1);
      reset = 1'b1;
      #1;
      check("rst_wait.req_async", 32'(dmem_req), 32'd0);
      tick();
      reset = 1'b0;
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h5555_5555;
      tick();
      dmem_ack   = 1'b0;
      #1;
      check("rst_wait.no_wbv", 32'(wb_valid), 32'd0);
      check("rst_wait.no_req", 32'(dmem_req), 32'd0);
      tick();
      check("rst_wait.no_wbv2", 32'(wb_valid), 32'd0);

      // Normal operation resumes after the aborted access
      mem_op("post_rst", 32'h0000_A001, 3'b100, 1'b0, 32'h0, 5'd22, 32'h0000_C300, 0,
             32'h0000_A000, 4'b0010, 32'h0, 32'h0000_00C3, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
